// File: rtl/matmul_pkg.sv
// Shared types and index helpers for the SRAM matrix-multiply engine.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_REQ = 3'd1,
        HDR_CHK = 3'd2,
        RUN     = 3'd3,
        DRAIN   = 3'd4
    } state_e;

    // Header word holds two DIM_W-wide fields; these select which one.
    localparam int HDR_LO_FIELD = 0;
    localparam int HDR_HI_FIELD = 1;

    // Index arithmetic is done at a fixed width and truncated to ADDR_W by the caller.
    localparam int IDX_W = 32;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t a_index(input idx_t m, input idx_t k, input idx_t kd);
        return idx_t'(1) + m * kd + k;
    endfunction

    // Stored B is row-major K x N.
    function automatic idx_t b_index_norm(input idx_t b, input idx_t k, input idx_t n,
                                          input idx_t kd, input idx_t nd);
        return idx_t'(1) + b * kd * nd + k * nd + n;
    endfunction

    // Stored B is row-major N x K, read back as its transpose.
    function automatic idx_t b_index_trans(input idx_t b, input idx_t k, input idx_t n,
                                           input idx_t kd, input idx_t nd);
        return idx_t'(1) + b * kd * nd + n * kd + k;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate stage: flags are delayed one cycle to line up with SRAM read data.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pair_valid_i,
    input  logic              first_i,
    input  logic              last_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              we_o,
    output logic [DATA_W-1:0] sum_o
);

    logic              valid_q, first_q, last_q;
    logic              we_q;
    logic [DATA_W-1:0] acc_q, acc_d;

    // Modular sum: restart on the first k, otherwise accumulate.
    always_comb begin
        acc_d = (first_q ? '0 : acc_q) + a_i * b_i;
    end

    // Flag pipeline aligned with the 1-cycle SRAM latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= pair_valid_i;
            first_q <= first_i;
            last_q  <= last_i;
        end
    end

    // Accumulator and write strobe; strobe fires once per finished dot product.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            we_q  <= 1'b0;
        end else begin
            we_q <= valid_q & last_q;
            if (valid_q) begin
                acc_q <= acc_d;
            end
        end
    end

    assign we_o  = we_q;
    assign sum_o = acc_q;

endmodule

// File: rtl/sram_matmul_engine.sv
// Streams A against NUM_B stacked B matrices and writes C_b = A x B_b row-major.
module sram_matmul_engine
    import matmul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 16,
    parameter int NUM_B  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dut_valid,
    output logic              dut_ready,
    input  logic              trans_b,
    output logic              err,
    output logic [ADDR_W-1:0] sram_a_read_address,
    input  logic [DATA_W-1:0] sram_a_read_data,
    output logic [ADDR_W-1:0] sram_b_read_address,
    input  logic [DATA_W-1:0] sram_b_read_data,
    output logic              sram_c_write_enable,
    output logic [ADDR_W-1:0] sram_c_write_address,
    output logic [DATA_W-1:0] sram_c_write_data
);

    state_e             state_q, state_d;
    logic               phase_q;
    logic               trans_q, ready_q, err_q;
    logic [DIM_W-1:0]   m_dim_q, k_dim_q, n_dim_q, kb_dim_q;
    logic [DIM_W-1:0]   k_q, n_q, m_q;
    logic [3:0]         b_q;
    logic [ADDR_W-1:0]  wr_addr_q;

    logic accept, dim_err, dim_zero;
    logic k_last, n_last, m_last, b_last, last_pair;
    logic pair_valid, mac_we;
    logic [DIM_W-1:0] a_hi, a_lo, b_hi, b_lo;

    assign accept    = dut_valid & ready_q;
    assign a_hi      = sram_a_read_data[HDR_HI_FIELD*DIM_W +: DIM_W];
    assign a_lo      = sram_a_read_data[HDR_LO_FIELD*DIM_W +: DIM_W];
    assign b_hi      = sram_b_read_data[HDR_HI_FIELD*DIM_W +: DIM_W];
    assign b_lo      = sram_b_read_data[HDR_LO_FIELD*DIM_W +: DIM_W];
    assign dim_err   = (k_dim_q != kb_dim_q);
    assign dim_zero  = (m_dim_q == '0) | (k_dim_q == '0) | (n_dim_q == '0);
    assign k_last    = (k_q == k_dim_q - DIM_W'(1));
    assign n_last    = (n_q == n_dim_q - DIM_W'(1));
    assign m_last    = (m_q == m_dim_q - DIM_W'(1));
    assign b_last    = (b_q == 4'(NUM_B - 1));
    assign last_pair = k_last & n_last & m_last & b_last;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; HDR_REQ and DRAIN each last two cycles, tracked by phase_q.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = HDR_REQ;
            HDR_REQ: if (phase_q) state_d = HDR_CHK;
            HDR_CHK: state_d = (dim_err | dim_zero) ? IDLE : RUN;
            RUN:     if (last_pair) state_d = DRAIN;
            DRAIN:   if (phase_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: element addresses and MAC flags while issuing pairs; address 0 otherwise.
    always_comb begin
        pair_valid          = 1'b0;
        sram_a_read_address = '0;
        sram_b_read_address = '0;
        if (state_q == RUN) begin
            pair_valid          = 1'b1;
            sram_a_read_address = ADDR_W'(a_index(idx_t'(m_q), idx_t'(k_q), idx_t'(k_dim_q)));
            sram_b_read_address = trans_q
                ? ADDR_W'(b_index_trans(idx_t'(b_q), idx_t'(k_q), idx_t'(n_q),
                                        idx_t'(k_dim_q), idx_t'(n_dim_q)))
                : ADDR_W'(b_index_norm(idx_t'(b_q), idx_t'(k_q), idx_t'(n_q),
                                       idx_t'(k_dim_q), idx_t'(n_dim_q)));
        end
    end

    // Job control: handshake, header capture, error flag and result address.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= 1'b0;
            trans_q   <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            m_dim_q   <= '0;
            k_dim_q   <= '0;
            n_dim_q   <= '0;
            kb_dim_q  <= '0;
            wr_addr_q <= '0;
        end else begin
            phase_q <= ((state_q == HDR_REQ) || (state_q == DRAIN)) && !phase_q;
            ready_q <= (state_d == IDLE);
            if (accept) begin
                trans_q   <= trans_b;
                err_q     <= 1'b0;
                wr_addr_q <= '0;
            end
            if ((state_q == HDR_REQ) && phase_q) begin
                m_dim_q <= a_hi;
                k_dim_q <= a_lo;
                if (trans_q) begin
                    n_dim_q  <= b_hi;
                    kb_dim_q <= b_lo;
                end else begin
                    kb_dim_q <= b_hi;
                    n_dim_q  <= b_lo;
                end
            end
            if ((state_q == HDR_CHK) && dim_err) err_q <= 1'b1;
            if (mac_we) wr_addr_q <= wr_addr_q + ADDR_W'(1);
        end
    end

    // Address counters: k innermost, then n, m, b; cleared whenever not issuing.
    always_ff @(posedge clk) begin
        if (reset || (state_q != RUN)) begin
            k_q <= '0;
            n_q <= '0;
            m_q <= '0;
            b_q <= '0;
        end else if (!k_last) begin
            k_q <= k_q + DIM_W'(1);
        end else begin
            k_q <= '0;
            if (!n_last) begin
                n_q <= n_q + DIM_W'(1);
            end else begin
                n_q <= '0;
                if (!m_last) begin
                    m_q <= m_q + DIM_W'(1);
                end else begin
                    m_q <= '0;
                    b_q <= b_q + 4'd1;
                end
            end
        end
    end

    matmul_mac #(.DATA_W(DATA_W)) u_mac (
        .clk          (clk),
        .reset        (reset),
        .pair_valid_i (pair_valid),
        .first_i      (k_q == '0),
        .last_i       (k_last),
        .a_i          (sram_a_read_data),
        .b_i          (sram_b_read_data),
        .we_o         (mac_we),
        .sum_o        (sram_c_write_data)
    );

    assign dut_ready            = ready_q;
    assign err                  = err_q;
    assign sram_c_write_enable  = mac_we;
    assign sram_c_write_address = wr_addr_q;

endmodule

// File: doc/sram_matmul_engine.md
Name: sram_matmul_engine

Overview:
- Parametrised successor to the fixed-function QKV/S matrix engine.
- Streams A (input SRAM) against NUM_B stacked B matrices (weight SRAM) and writes NUM_B results C_b = A x B_b, row-major, to result SRAM.
- Adds the following over the fixed engine:
  - runtime transpose mode for B;
  - header dimension checking with an error flag;
  - zero-dimension early exit;
  - configurable data/address width and matrix count.

Parameters:
- DATA_W, 32, SRAM word, element and accumulator width.
- ADDR_W, 16, SRAM address width.
- DIM_W, 16, width of each header dimension field (2*DIM_W <= DATA_W).
- NUM_B, 3, number of B matrices stacked in weight SRAM (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- dut_valid  in  1  start request
- dut_ready  out  1  idle/done indicator
- trans_b  in  1  sampled at start: 1 = treat each stored B as B^T
- err  out  1  dimension mismatch on last job, sticky until next start
- sram_a_read_address  out  ADDR_W  input SRAM read address
- sram_a_read_data  in  DATA_W  input SRAM data, 1-cycle latency
- sram_b_read_address  out  ADDR_W  weight SRAM read address
- sram_b_read_data  in  DATA_W  weight SRAM data, 1-cycle latency
- sram_c_write_enable  out  1  result write strobe
- sram_c_write_address  out  ADDR_W  result write address
- sram_c_write_data  out  DATA_W  result write data

Behaviour:
- Reset (synchronous, active-high) values:
  - dut_ready=0, err=0, sram_c_write_enable=0, all addresses 0.
  - FSM goes to IDLE; dut_ready rises the first cycle after reset deasserts.
- Reset asserted mid-job: aborts the job next edge; no further writes; partial results remain in SRAM.
- Handshake:
  - A start is accepted on a clk edge with dut_valid=1 && dut_ready=1; dut_ready drops the next cycle.
  - dut_ready rises the cycle after the final write, or after an error/zero exit.
  - dut_valid while busy is ignored.
- SRAM timing: address presented in cycle n; data registered at edge n+1. Read data is never used combinationally into write data.
- A layout:
  - addr 0 header: [2*DIM_W-1:DIM_W]=M, [DIM_W-1:0]=K.
  - Element (m,k) at 1 + m*K + k.
- B layout:
  - addr 0 header: [hi]=R, [lo]=Cn.
  - trans_b=0: K_b=R, N=Cn; element (k,n) of matrix b at 1 + b*K*N + k*N + n.
  - trans_b=1: N=R, K_b=Cn; element (k,n) at 1 + b*K*N + n*K + k.
- Result layout: C_b(m,n) at b*M*N + m*N + n.
- Write order: b outer, m, n inner; addresses strictly increasing by 1.
- FSM states:
  - IDLE -> HDR_REQ on start: drive address 0 on both SRAMs; latch trans_b.
  - HDR_REQ -> HDR_CHK: register both headers.
  - HDR_CHK:
    - K != K_b: set err=1 -> IDLE, no writes.
    - Any of M, K, N == 0: -> IDLE, err=0, no writes.
    - Otherwise -> RUN.
  - RUN: one A/B element pair issued per cycle with no bubbles, including across row, column and matrix boundaries. Address generator holds counters k, n, m, b.
  - RUN -> DRAIN after the last pair issues.
  - DRAIN: 2 cycles for the SRAM and MAC stages -> IDLE.
- MAC:
  - acc <= (first k) ? a*b : acc + a*b.
  - Product and sum are truncated to the low DATA_W bits (modular; identical for signed and unsigned).
  - On the last k, write enable asserts with data = final sum, exactly once per (b,m,n).
- Throughput and latency:
  - One result every K cycles.
  - Start accept to dut_ready high = 3 + NUM_B*M*N*K + 2 cycles.
- Address overflow: no wrap checking; the caller guarantees all layouts fit in 2^ADDR_W.

Decomposition:
- Package matmul_pkg holds:
  - state enum (IDLE, HDR_REQ, HDR_CHK, RUN, DRAIN);
  - header field slice constants;
  - helper functions for B element index (normal and transposed).
- One sub-module, matmul_mac:
  - inputs: pair-valid, first/last flags, a, b;
  - outputs: write strobe and sum;
  - flags travel with data through a 1-deep pipeline.
- The top holds the FSM, header registers and address counters.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], NUM_B=1, trans_b=0 -> writes 19,22,43,50 to addrs 0..3; dut_ready high 3+8+2 cycles after accept.
- Same data, trans_b=1 (stored header R=2, Cn=2) -> writes 17,23,39,53 to addrs 0..3.
- NUM_B=3, A 2x3, three distinct 3x2 B matrices -> 12 writes at addrs 0..11 matching the golden model; no write-enable gap longer than K-1 cycles.
- A header K=3, B header R=2 -> err=1, zero writes, dut_ready back 3 cycles after accept; next valid job clears err.
- A=[[0xFFFFFFFF]], B=[[2]] (1x1) -> writes 0xFFFFFFFE to addr 0.
- Reset asserted at the 5th RUN cycle of a 4x4x4 job -> write enable low from the next edge; dut_ready=0 during reset, 1 after release; a fresh job then completes correctly.
